// File: rtl/game_pkg.sv
// game_pkg: key byte codes, decoded-key bundle and FSM state types shared by the
// terminal game serial input path.
package game_pkg;
    localparam logic [7:0] KEY_W      = 8'h77;
    localparam logic [7:0] KEY_S      = 8'h73;
    localparam logic [7:0] KEY_A      = 8'h61;
    localparam logic [7:0] KEY_D      = 8'h64;
    localparam logic [7:0] KEY_SPACE  = 8'h20;
    localparam logic [7:0] KEY_CR     = 8'h0D;
    localparam logic [7:0] KEY_ESC    = 8'h1B;
    localparam logic [7:0] KEY_LBRACK = 8'h5B;
    localparam logic [7:0] CSI_UP     = 8'h41;
    localparam logic [7:0] CSI_DOWN   = 8'h42;
    localparam logic [7:0] CSI_RIGHT  = 8'h43;
    localparam logic [7:0] CSI_LEFT   = 8'h44;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic center;
    } keys_t;

    typedef enum logic [1:0] {D_IDLE, D_ESC, D_CSI} dec_state_e;
    typedef enum logic [2:0] {ARM, IDLE, START, DATA, STOP} rx_state_e;

    // Setting bit 5 folds upper-case ASCII letters onto lower case.
    function automatic keys_t wasd_keys(input logic [7:0] b);
        keys_t k;
        logic [7:0] l;
        l = b | 8'h20;
        k.up     = l == KEY_W;
        k.down   = l == KEY_S;
        k.left   = l == KEY_A;
        k.right  = l == KEY_D;
        k.center = b == KEY_SPACE || b == KEY_CR;
        return k;
    endfunction

    function automatic keys_t csi_keys(input logic [7:0] b);
        keys_t k;
        k.up     = b == CSI_UP;
        k.down   = b == CSI_DOWN;
        k.left   = b == CSI_LEFT;
        k.right  = b == CSI_RIGHT;
        k.center = 1'b0;
        return k;
    endfunction
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 receiver with 2-FF input synchronizer; emits one-cycle
// rx_valid / frame_err pulses and holds the last good byte.
module uart_rx_byte #(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);
    import game_pkg::*;
    localparam int BIT_CYC  = CLK_HZ / BAUD;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CW       = $clog2(BIT_CYC);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);

    logic          sync1_q, sync2_q;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sr_q, sr_d, byte_q, byte_d;
    logic          valid_q, valid_d, ferr_q, ferr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= ARM;
            cnt_q   <= '0;
            idx_q   <= '0;
            sr_q    <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= RxD;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        sr_d    = sr_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            ARM: begin
                cnt_d   = '0;
                state_d = sync2_q ? IDLE : ARM;
            end
            IDLE: begin
                cnt_d   = '0;
                state_d = sync2_q ? IDLE : START;
            end
            START: if (cnt_q == HALF_LAST) begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = sync2_q ? IDLE : DATA;
            end
            DATA: if (cnt_q == BIT_LAST) begin
                cnt_d   = '0;
                sr_d    = {sync2_q, sr_q[7:1]};
                idx_d   = idx_q + 1'b1;
                state_d = idx_q == 3'd7 ? STOP : DATA;
            end
            STOP: if (cnt_q == BIT_LAST) begin
                cnt_d   = '0;
                valid_d = sync2_q;
                ferr_d  = !sync2_q;
                byte_d  = sync2_q ? sr_q : byte_q;
                state_d = sync2_q ? IDLE : ARM;
            end
            default: begin
                cnt_d   = '0;
                state_d = ARM;
            end
        endcase
    end

    assign rx_byte   = byte_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
endmodule

// File: rtl/uart_key_decoder.sv
// uart_key_decoder: turns received terminal bytes (WASD, space/CR, ANSI arrow
// escapes) into one-cycle movement pulses for the player-position logic.
module uart_key_decoder #(
    parameter int CLK_HZ      = 100000000,
    parameter int BAUD        = 9600,
    parameter int ESC_TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic       key_up,
    output logic       key_down,
    output logic       key_left,
    output logic       key_right,
    output logic       key_center,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);
    import game_pkg::*;
    localparam int TW = $clog2(ESC_TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(ESC_TIMEOUT - 1);

    dec_state_e    dec_q, dec_d;
    logic [TW-1:0] to_q, to_d;
    keys_t         keys_q, keys_d;
    logic          abandon;

    uart_rx_byte #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .RxD      (RxD),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .frame_err(frame_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q  <= D_IDLE;
            to_q   <= '0;
            keys_q <= '0;
        end else begin
            dec_q  <= dec_d;
            to_q   <= to_d;
            keys_q <= keys_d;
        end
    end

    // A stalled or corrupted escape sequence drops back to plain key decoding.
    assign abandon = to_q == TO_LAST || frame_err;

    always_comb begin
        dec_d  = dec_q;
        to_d   = to_q;
        keys_d = '0;
        if (rx_valid) begin
            to_d   = '0;
            keys_d = dec_q == D_IDLE ? wasd_keys(rx_byte) :
                     dec_q == D_CSI  ? csi_keys(rx_byte) : '0;
            dec_d  = dec_q == D_IDLE && rx_byte == KEY_ESC    ? D_ESC :
                     dec_q == D_ESC  && rx_byte == KEY_LBRACK ? D_CSI : D_IDLE;
        end else if (dec_q != D_IDLE) begin
            to_d  = abandon ? '0 : to_q + 1'b1;
            dec_d = abandon ? D_IDLE : dec_q;
        end
    end

    assign key_up     = keys_q.up;
    assign key_down   = keys_q.down;
    assign key_left   = keys_q.left;
    assign key_right  = keys_q.right;
    assign key_center = keys_q.center;
endmodule

// File: tb/tb_uart_key_decoder.sv
// tb_uart_key_decoder: table-driven, directed and randomized checks of the
// UART key decoder against a byte-level keystroke model.
module tb_uart_key_decoder;
    localparam int CLK_HZ      = 1000;
    localparam int BAUD        = 100;
    localparam int ESC_TIMEOUT = 200;
    localparam int BIT         = CLK_HZ / BAUD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RxD = 1'b1;
    logic       key_up, key_down, key_left, key_right, key_center;
    logic [7:0] rx_byte;
    logic       rx_valid, frame_err;

    uart_key_decoder #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ESC_TIMEOUT(ESC_TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .RxD       (RxD),
        .key_up    (key_up),
        .key_down  (key_down),
        .key_left  (key_left),
        .key_right (key_right),
        .key_center(key_center),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // key codes: 0 up, 1 down, 2 left, 3 right, 4 center, -1 none
    typedef struct {
        logic [7:0] b;
        int         key;
    } vec_t;

    int         cyc = 0;
    int         passed = 0;
    int         total = 0;
    int         key_q[$];
    int         key_cyc[$];
    logic [7:0] rxv_q[$];
    int         rxv_cyc[$];
    int         ferr_n = 0;
    int         multi_n = 0;
    logic [7:0] last_ok = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        int n;
        n = int'(key_up) + int'(key_down) + int'(key_left) + int'(key_right) + int'(key_center);
        if (n > 1) multi_n++;
        if (n > 0) begin
            key_q.push_back(key_up ? 0 : key_down ? 1 : key_left ? 2 : key_right ? 3 : 4);
            key_cyc.push_back(cyc);
        end
        if (rx_valid) begin
            rxv_q.push_back(rx_byte);
            rxv_cyc.push_back(cyc);
        end
        if (frame_err) ferr_n++;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear();
        key_q.delete();
        key_cyc.delete();
        rxv_q.delete();
        rxv_cyc.delete();
        ferr_n = 0;
    endtask

    // Called at a negedge; leaves RxD at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        RxD = 1'b0;
        idle(BIT);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            idle(BIT);
        end
        RxD = stop;
        idle(BIT);
        if (stop) last_ok = b;
    endtask

    function automatic int first_key();
        return key_q.size() > 0 ? key_q[0] : -99;
    endfunction

    function automatic int plain_key(input logic [7:0] b);
        case (b)
            8'h77, 8'h57: return 0;
            8'h73, 8'h53: return 1;
            8'h61, 8'h41: return 2;
            8'h64, 8'h44: return 3;
            8'h20, 8'h0D: return 4;
            default:      return -1;
        endcase
    endfunction

    function automatic int arrow_key(input logic [7:0] b);
        case (b)
            8'h41:   return 0;
            8'h42:   return 1;
            8'h43:   return 3;
            8'h44:   return 2;
            default: return -1;
        endcase
    endfunction

    initial begin
        vec_t       vecs[14];
        logic [7:0] pool[19];
        logic [7:0] sent[$];
        int         exp_keys[$];
        int         mode;
        int         k;
        int         bad;

        vecs = '{'{8'h77, 0}, '{8'h57, 0}, '{8'h73, 1}, '{8'h53, 1}, '{8'h61, 2},
                 '{8'h41, 2}, '{8'h64, 3}, '{8'h44, 3}, '{8'h20, 4}, '{8'h0D, 4},
                 '{8'h42, -1}, '{8'h5B, -1}, '{8'h00, -1}, '{8'h78, -1}};
        pool = '{8'h77, 8'h57, 8'h73, 8'h53, 8'h61, 8'h41, 8'h64, 8'h44, 8'h20, 8'h0D,
                 8'h1B, 8'h1B, 8'h5B, 8'h5B, 8'h43, 8'h42, 8'h00, 8'hFF, 8'h7A};

        // reset state
        idle(3);
        chk("reset_rx_byte", int'(rx_byte), 0);
        chk("reset_pulses", int'({key_up, key_down, key_left, key_right, key_center, rx_valid, frame_err}), 0);
        rst = 1'b0;
        idle(20);
        clear();

        // single key with exact latency
        k = cyc;
        send_frame(8'h77, 1'b1);
        idle(5);
        chk("single_rxv_count", rxv_q.size(), 1);
        chk("single_rx_byte", int'(rx_byte), 8'h77);
        chk("single_stop_latency", rxv_cyc.size() > 0 ? rxv_cyc[0] - k : -1, 3 + BIT / 2 + 9 * BIT);
        chk("single_key_count", key_q.size(), 1);
        chk("single_key_code", first_key(), 0);
        chk("single_key_latency", (key_cyc.size() > 0 && rxv_cyc.size() > 0) ? key_cyc[0] - rxv_cyc[0] : -1, 1);

        // table of single bytes decoded from D_IDLE
        foreach (vecs[i]) begin
            clear();
            send_frame(vecs[i].b, 1'b1);
            idle(4);
            chk($sformatf("vec%0d_rx_byte", i), int'(rx_byte), int'(vecs[i].b));
            chk($sformatf("vec%0d_rxv", i), rxv_q.size(), 1);
            chk($sformatf("vec%0d_key_count", i), key_q.size(), vecs[i].key >= 0 ? 1 : 0);
            if (vecs[i].key >= 0) chk($sformatf("vec%0d_key", i), first_key(), vecs[i].key);
        end

        // arrow sequence back-to-back
        clear();
        send_frame(8'h1B, 1'b1);
        send_frame(8'h5B, 1'b1);
        send_frame(8'h43, 1'b1);
        idle(5);
        chk("arrow_rxv_count", rxv_q.size(), 3);
        chk("arrow_key_count", key_q.size(), 1);
        chk("arrow_key", first_key(), 3);

        // ESC then letter inside the timeout: the letter is discarded
        clear();
        send_frame(8'h1B, 1'b1);
        idle(50);
        send_frame(8'h41, 1'b1);
        idle(5);
        chk("esc_discard_keys", key_q.size(), 0);

        // ESC timeout returns to plain decoding
        clear();
        send_frame(8'h1B, 1'b1);
        idle(250);
        send_frame(8'h41, 1'b1);
        idle(5);
        chk("esc_timeout_key_count", key_q.size(), 1);
        chk("esc_timeout_key", first_key(), 2);

        // CSI timeout
        clear();
        send_frame(8'h1B, 1'b1);
        send_frame(8'h5B, 1'b1);
        idle(250);
        send_frame(8'h44, 1'b1);
        idle(5);
        chk("csi_timeout_key", first_key(), 3);

        // framing error, line held low, recovery
        clear();
        send_frame(8'h64, 1'b0);
        idle(50);
        RxD = 1'b1;
        idle(20);
        chk("ferr_count", ferr_n, 1);
        chk("ferr_rxv", rxv_q.size(), 0);
        chk("ferr_keys", key_q.size(), 0);
        chk("ferr_rx_byte_held", int'(rx_byte), int'(last_ok));
        send_frame(8'h73, 1'b1);
        idle(5);
        chk("ferr_recover_key", first_key(), 1);
        chk("ferr_recover_count", key_q.size(), 1);

        // framing error inside an escape sequence cancels it
        clear();
        send_frame(8'h1B, 1'b1);
        send_frame(8'h5B, 1'b1);
        send_frame(8'h00, 1'b0);
        RxD = 1'b1;
        idle(20);
        send_frame(8'h44, 1'b1);
        idle(5);
        chk("ferr_esc_key", first_key(), 3);

        // false start glitch
        clear();
        RxD = 1'b0;
        idle(3);
        RxD = 1'b1;
        idle(30);
        chk("glitch_rxv", rxv_q.size(), 0);
        chk("glitch_ferr", ferr_n, 0);
        send_frame(8'h20, 1'b1);
        idle(5);
        chk("glitch_then_center", first_key(), 4);

        // reset during bit 4
        clear();
        fork
            send_frame(8'h61, 1'b1);
            begin
                idle(5 * BIT + 5);
                rst = 1'b1;
            end
        join
        chk("midreset_rx_byte", int'(rx_byte), 0);
        chk("midreset_pulses", int'({key_up, key_down, key_left, key_right, key_center, rx_valid, frame_err}), 0);
        idle(3);
        rst = 1'b0;
        idle(20);
        chk("midreset_no_events", rxv_q.size() + key_q.size() + ferr_n, 0);
        send_frame(8'h61, 1'b1);
        idle(5);
        chk("midreset_recover_key", first_key(), 2);

        // randomized bytes against the keystroke model
        clear();
        mode = 0;
        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            int         gap;
            int         e;
            b   = pool[$urandom_range(0, 18)];
            gap = ($urandom_range(0, 9) == 0) ? 250 : $urandom_range(0, 30);
            idle(gap);
            send_frame(b, 1'b1);
            sent.push_back(b);
            if (gap >= ESC_TIMEOUT) mode = 0;
            if (mode == 2) begin
                e    = arrow_key(b);
                mode = 0;
            end else if (mode == 1) begin
                e    = -1;
                mode = (b == 8'h5B) ? 2 : 0;
            end else begin
                e    = plain_key(b);
                mode = (b == 8'h1B) ? 1 : 0;
            end
            if (e >= 0) exp_keys.push_back(e);
        end
        idle(5);
        chk("rand_rxv_count", rxv_q.size(), sent.size());
        chk("rand_key_count", key_q.size(), exp_keys.size());
        foreach (sent[i]) if (i < rxv_q.size()) chk($sformatf("rand_byte%0d", i), int'(rxv_q[i]), int'(sent[i]));
        foreach (exp_keys[i]) if (i < key_q.size()) chk($sformatf("rand_key%0d", i), key_q[i], exp_keys[i]);
        bad = 0;
        foreach (key_cyc[i]) begin
            int hit;
            hit = 0;
            foreach (rxv_cyc[j]) if (rxv_cyc[j] == key_cyc[i] - 1) hit = 1;
            if (hit == 0) bad++;
        end
        chk("rand_key_latency_misses", bad, 0);
        chk("onehot_violations", multi_n, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
